// File: rtl/ps2_pkg.sv
// ps2_pkg: shared transmitter states and PS/2 frame constants.
//   tx_state_t : per-channel transmitter FSM state (IDLE, D0..D7, PAR, STOP, DONE)
//   START_BIT  : line level of the frame start bit
//   STOP_BIT   : line level of the frame stop bit
package ps2_pkg;
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_D0   = 4'd1,
      ST_D1   = 4'd2,
      ST_D2   = 4'd3,
      ST_D3   = 4'd4,
      ST_D4   = 4'd5,
      ST_D5   = 4'd6,
      ST_D6   = 4'd7,
      ST_D7   = 4'd8,
      ST_PAR  = 4'd9,
      ST_STOP = 4'd10,
      ST_DONE = 4'd11
   } tx_state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/ps2_tx_chan.sv
// ps2_tx_chan: one device-to-host PS/2 transmitter with its byte FIFO.
//   clk_sys, rst_n : system clock, async active-low reset
//   tick           : one-cycle strobe where the shared PS/2 clock rises
//   clk_ps2        : shared divided PS/2 clock
//   we, data       : byte write strobe and byte for this channel
//   inhibit        : host holding the PS/2 clock low
//   clr            : clear the sticky overflow flag
//   ps2_clk/ps2_data : emulated PS/2 lines, high when idle
//   busy, overflow, level : frame in progress, sticky drop flag, FIFO occupancy
module ps2_tx_chan
   import ps2_pkg::*;
#(
   parameter int FIFO_BITS = 3
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               clk_ps2,
   input  logic               we,
   input  logic [7:0]         data,
   input  logic               inhibit,
   input  logic               clr,
   output logic               ps2_clk,
   output logic               ps2_data,
   output logic               busy,
   output logic               overflow,
   output logic [FIFO_BITS:0] level
);
   localparam int DEPTH = 1 << FIFO_BITS;

   logic [7:0]           mem [DEPTH];
   logic [FIFO_BITS-1:0] wptr, rptr;
   logic [7:0]           shreg;
   logic                 parity;
   tx_state_t            state;
   logic                 full, pop, push;

   assign full    = level == (FIFO_BITS+1)'(DEPTH);
   assign pop     = tick && state == ST_DONE;
   // a pop in the same cycle frees the slot the write needs
   assign push    = we && (!full || pop);
   assign ps2_clk = clk_ps2 | (state == ST_IDLE);
   assign busy    = state != ST_IDLE;

   always_ff @(posedge clk_sys)
      if (push) mem[wptr] <= data;

   always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
         state    <= ST_IDLE;
         shreg    <= '0;
         parity   <= 1'b0;
         ps2_data <= 1'b1;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         level    <= level + (FIFO_BITS+1)'(push) - (FIFO_BITS+1)'(pop);
         overflow <= (we && !push) ? 1'b1 : clr ? 1'b0 : overflow;
         if (tick) begin
            if (state == ST_IDLE) begin
               // head byte is only copied; it stays queued until DONE so an abort can resend it
               if (level != '0 && !inhibit) begin
                  shreg    <= mem[rptr];
                  parity   <= 1'b1;
                  ps2_data <= START_BIT;
                  state    <= ST_D0;
               end
            end else if (state <= ST_PAR && inhibit) begin
               ps2_data <= 1'b1;
               state    <= ST_IDLE;
            end else if (state <= ST_D7) begin
               ps2_data <= shreg[0];
               parity   <= parity ^ shreg[0];
               shreg    <= {1'b0, shreg[7:1]};
               state    <= tx_state_t'(state + 4'd1);
            end else if (state == ST_PAR) begin
               ps2_data <= parity;
               state    <= ST_STOP;
            end else if (state == ST_STOP) begin
               ps2_data <= STOP_BIT;
               state    <= ST_DONE;
            end else begin
               ps2_data <= 1'b1;
               state    <= ST_IDLE;
            end
         end
      end
endmodule

// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: CHANNELS independent PS/2 device transmitters on one shared bit clock.
//   clk_sys, rst_n        : system clock, async active-low reset
//   wr, wr_chan, wr_data  : byte write strobe, target channel, byte
//   clr_overflow          : per-channel sticky overflow clear
//   inhibit               : per-channel host inhibit (already synchronised)
//   ps2_clk, ps2_data     : per-channel emulated PS/2 lines
//   busy, overflow        : per-channel frame-in-progress and dropped-byte flags
//   level                 : per-channel FIFO occupancy, FIFO_BITS+1 bits each
module ps2_tx_multi
   import ps2_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3,
   parameter int PS2DIV    = 100
) (
   input  logic                            clk_sys,
   input  logic                            rst_n,
   input  logic                            wr,
   input  logic [2:0]                      wr_chan,
   input  logic [7:0]                      wr_data,
   input  logic [CHANNELS-1:0]             clr_overflow,
   input  logic [CHANNELS-1:0]             inhibit,
   output logic [CHANNELS-1:0]             ps2_clk,
   output logic [CHANNELS-1:0]             ps2_data,
   output logic [CHANNELS-1:0]             busy,
   output logic [CHANNELS-1:0]             overflow,
   output logic [CHANNELS*(FIFO_BITS+1)-1:0] level
);
   localparam int DW = $clog2(PS2DIV + 2);

   logic [DW-1:0] div;
   logic          clk_ps2, tick;

   assign tick = div == DW'(PS2DIV) && !clk_ps2;

   always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) begin
         div     <= '0;
         clk_ps2 <= 1'b0;
      end else if (div == DW'(PS2DIV)) begin
         div     <= '0;
         clk_ps2 <= ~clk_ps2;
      end else begin
         div <= div + DW'(1);
      end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      ps2_tx_chan #(.FIFO_BITS(FIFO_BITS)) u_chan (
         .clk_sys  (clk_sys),
         .rst_n    (rst_n),
         .tick     (tick),
         .clk_ps2  (clk_ps2),
         .we       (wr && wr_chan == 3'(i)),
         .data     (wr_data),
         .inhibit  (inhibit[i]),
         .clr      (clr_overflow[i]),
         .ps2_clk  (ps2_clk[i]),
         .ps2_data (ps2_data[i]),
         .busy     (busy[i]),
         .overflow (overflow[i]),
         .level    (level[i*(FIFO_BITS+1) +: FIFO_BITS+1])
      );
   end
endmodule

// File: doc/ps2_tx_multi.md
Name: ps2_tx_multi

Overview:
- Parametrised successor of the fixed keyboard/mouse PS/2 emulation transmitters in the ARM-to-core IO path.
- CHANNELS independent device-to-host PS/2 transmitters, each with a byte FIFO of depth 2^FIFO_BITS, share one divided PS/2 bit clock.
- New behaviour: host-inhibit abort and retransmit, sticky overflow flags, and FIFO level reporting.
- Sits between the SPI command decoder (bytes already in clk_sys) and the core's PS/2 controllers.

Parameters:
CHANNELS, 2, number of PS/2 devices (0 = keyboard, 1 = mouse by convention); range 1..8
FIFO_BITS, 3, log2 FIFO depth per channel; range 1..6
PS2DIV, 100, divider terminal count; bit period = 2*(PS2DIV+1) clk_sys cycles

Ports:
clk_sys  in  1  system clock, the only clock
rst_n  in  1  asynchronous active-low reset
wr  in  1  byte write strobe, one cycle per byte
wr_chan  in  3  target channel for wr
wr_data  in  8  byte to queue
clr_overflow  in  CHANNELS  per-channel overflow clear, one cycle
inhibit  in  CHANNELS  host holding PS/2 clock low, already synchronised
ps2_clk  out  CHANNELS  emulated PS/2 clock, high when idle
ps2_data  out  CHANNELS  emulated PS/2 data, high when idle
busy  out  CHANNELS  frame in progress
overflow  out  CHANNELS  sticky: byte dropped on full FIFO
level  out  CHANNELS*(FIFO_BITS+1)  per-channel FIFO occupancy; channel i in bits [i*(FIFO_BITS+1) +: FIFO_BITS+1]

Behaviour:
- Reset state:
  - ps2_clk = all 1, ps2_data = all 1, busy = 0, overflow = 0, level = 0.
  - FIFO pointers = 0, divider count = 0, internal clk_ps2 = 0, all transmitters in IDLE.
- Divider: counter increments each clk_sys cycle. At PS2DIV it clears and clk_ps2 toggles. A tick is the single clk_sys cycle in which clk_ps2 rises.
- Write path:
  - wr with wr_chan < CHANNELS and FIFO not full: store wr_data at wptr, wptr + 1, level + 1, effective next cycle.
  - wr_chan >= CHANNELS: ignored, no flag.
  - Write to a full FIFO: byte dropped, overflow[ch] set.
  - Write to a full FIFO in the same cycle as that channel's pop: the write is accepted.
  - Same-cycle set and clr_overflow: set wins.
- Pointer arithmetic: pointers FIFO_BITS wide and wrap modulo depth. level = wptr - rptr with an extra MSB so a full FIFO reads 2^FIFO_BITS.
- Transmitter FSM per channel (state 4 bits), advancing only on tick:
  - IDLE: if level != 0 and !inhibit, latch head byte (no pop), parity = 1, drive ps2_data = 0 (start bit), go to D0.
  - D0..D7: drive the shifted byte LSB first; parity toggles on each 1.
  - PAR: drive parity (odd parity over data + parity).
  - STOP: drive 1.
  - DONE: ps2_data = 1, pop (rptr + 1), return to IDLE.
  - A frame spans 12 ticks from start bit to IDLE.
- ps2_clk[ch] = clk_ps2 OR (state == IDLE). busy[ch] = (state != IDLE).
- Inhibit handling:
  - inhibit high in any state D0..PAR: on the next tick go to IDLE, ps2_data = 1, no pop. The same byte is resent in full after inhibit releases.
  - inhibit in STOP or DONE: ignored, frame completes and pops.
  - In IDLE, inhibit blocks new frame starts.
- Channels are fully independent. All transmitters tick on the same cycle, so frames on different channels may overlap.
- Reset mid-frame: line returns high immediately (async) and all queued bytes are discarded.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state localparams: ST_IDLE = 0, ST_D0 = 1 .. ST_D7 = 8, ST_PAR = 9, ST_STOP = 10, ST_DONE = 11.
  - Frame constants: START_BIT = 0, STOP_BIT = 1.
- Sub-module ps2_tx_chan holds FIFO, pointers, level, overflow and FSM for one channel. Inputs: tick, write enable, data, inhibit, clr.
- Top instantiates ps2_tx_chan CHANNELS times via generate, plus the shared divider and write-channel decode.

Test Plan:
- Basic frame: PS2DIV=2, wr ch0 byte 0x1C -> ps2_data[0] on successive ticks 0,0,0,1,1,1,0,0,0,0(parity),1(stop), then idle 1. Ticks are 6 cycles apart. ps2_clk[0] toggles only while busy; level returns 0 after DONE.
- Overflow: FIFO_BITS=3, 9 writes to ch1 with transmitter inhibited -> level = 8, overflow[1] = 1, 9th byte lost. clr_overflow[1] -> overflow[1] = 0.
- Inhibit abort: inhibit[0] raised during D4 of byte 0xAA -> idle at next tick, level unchanged at 1. After release, full frame 0,0,1,0,1,0,1,0,1,1,1 is sent.
- Independence and wrap: write 0x12 to ch0 and 0x34 to ch1 in consecutive cycles -> both frames start on the same tick with correct bits. Then 20 sequential bytes on ch0 -> all emitted in order across pointer wrap.
- Edge cases: wr_chan = 5 with CHANNELS = 2 -> no level change. Write on the same cycle as a pop into a full FIFO -> accepted, level stays 8, no overflow.
- Async reset mid-PAR -> ps2_data = 1, ps2_clk = 1, level = 0 while rst_n is low. Next frame after release is correct.
